// File: rtl/svo_tcard_seq_if.sv
// Stream monitor tap for the SVO test-card sequencer: a read-only view of the
// generator's output handshake and start-of-frame flag.
interface svo_tcard_seq_if;
  logic mon_tvalid;
  logic mon_tready;
  logic mon_tuser;

  modport master (output mon_tvalid, mon_tready, mon_tuser);
  modport slave  (input  mon_tvalid, mon_tready, mon_tuser);
endinterface

// File: rtl/svo_tcard_seq.sv
// Frame-synchronous colour-wheel / sprite sequencer for the SVO test card.
// Optional sprite bounce motion: define SVO_TCARD_SEQ_BOUNCE_EN.
module svo_tcard_seq #(
  parameter int BITS_PER_COMPONENT = 8,
  parameter int FRAME_DIV          = 1,
  parameter int STEP               = 1,
  parameter int HOR_PIXELS         = 640,
  parameter int SPRITE_W           = 320
) (
  input  logic                          clk,
  input  logic                          resetn,
  svo_tcard_seq_if.slave                mon,
  input  logic                          enable,
  input  logic                          freeze,
  input  logic                          step_req,
  output logic [BITS_PER_COMPONENT-1:0] base_r,
  output logic [BITS_PER_COMPONENT-1:0] base_g,
  output logic [BITS_PER_COMPONENT-1:0] base_b,
  output logic [15:0]                   sprite_x,
  output logic [1:0]                    phase,
  output logic [15:0]                   frame_cnt,
  output logic                          sof_pulse
);
  localparam int B = BITS_PER_COMPONENT;
  localparam logic [B-1:0] LP_FS       = {B{1'b1}};
  localparam logic [B-1:0] LP_STEP     = B'(STEP);
  localparam logic [15:0]  LP_DIV_LAST = 16'(FRAME_DIV - 1);
  localparam logic [15:0]  LP_XMAX     = 16'(HOR_PIXELS - SPRITE_W);
  localparam logic [15:0]  LP_XMID     = 16'((HOR_PIXELS - SPRITE_W) / 2);

  typedef enum logic [1:0] {PH_RED = 2'd0, PH_GREEN = 2'd1, PH_BLUE = 2'd2, PH_ILL = 2'd3} phase_e;

  phase_e       r_phase, w_phase_nxt;
  logic [B-1:0] r_int, w_int_nxt;
  logic [15:0]  r_div;
  logic         r_armed;
  logic [B-1:0] r_base_r, r_base_g, r_base_b;
  logic [B-1:0] w_r_nxt, w_g_nxt, w_b_nxt;
  logic [15:0]  r_frame_cnt;
  logic         r_sof;

  logic w_fe, w_run, w_div_adv, w_div_wrap, w_step;

  assign w_fe       = mon.mon_tvalid & mon.mon_tready & mon.mon_tuser;
  assign w_run      = w_fe & enable;
  assign w_div_adv  = w_run & ~freeze;
  assign w_div_wrap = (r_div == LP_DIV_LAST);
  // An armed single step fires on the next enabled FE whatever freeze is doing then.
  assign w_step     = (w_div_adv & w_div_wrap) | (w_run & r_armed);

  // Colour-wheel state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_phase <= PH_RED;
      r_int   <= LP_FS;
    end else begin
      r_phase <= w_phase_nxt;
      r_int   <= w_int_nxt;
    end
  end

  // Colour-wheel next state
  always_comb begin
    w_phase_nxt = r_phase;
    w_int_nxt   = r_int;
    if (w_fe && r_phase == PH_ILL) begin
      w_phase_nxt = PH_RED;
      w_int_nxt   = LP_FS;
    end else if (w_step) begin
      if (r_int == '0) begin
        w_int_nxt = LP_FS;
        case (r_phase)
          PH_RED:   w_phase_nxt = PH_GREEN;
          PH_GREEN: w_phase_nxt = PH_BLUE;
          default:  w_phase_nxt = PH_RED;
        endcase
      end else begin
        w_int_nxt = (r_int < LP_STEP) ? '0 : r_int - LP_STEP;
      end
    end
  end

  // Colour mix of the state being committed, so base_* and phase move together
  always_comb begin
    w_r_nxt = '0;
    w_g_nxt = '0;
    w_b_nxt = '0;
    case (w_phase_nxt)
      PH_GREEN: begin w_g_nxt = w_int_nxt;         w_b_nxt = LP_FS - w_int_nxt; end
      PH_BLUE:  begin w_r_nxt = LP_FS - w_int_nxt; w_b_nxt = w_int_nxt;         end
      default:  begin w_r_nxt = w_int_nxt;         w_g_nxt = LP_FS - w_int_nxt; end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_base_r <= LP_FS;
      r_base_g <= '0;
      r_base_b <= '0;
    end else if (w_fe) begin
      r_base_r <= w_r_nxt;
      r_base_g <= w_g_nxt;
      r_base_b <= w_b_nxt;
    end
  end

  // Frame divider and single-step arm; a new request wins over consumption
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div   <= '0;
      r_armed <= 1'b0;
    end else begin
      if (w_div_adv)
        r_div <= w_div_wrap ? '0 : r_div + 16'd1;
      if (freeze && step_req)
        r_armed <= 1'b1;
      else if (w_run)
        r_armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_cnt <= '0;
      r_sof       <= 1'b0;
    end else begin
      r_sof <= w_fe;
      if (w_fe)
        r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

`ifdef SVO_TCARD_SEQ_BOUNCE_EN
  logic        r_dir_left;
  logic [15:0] r_sprite_x;

  // Reversal at an endpoint moves away in the same FE, so no position repeats
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sprite_x <= LP_XMID;
      r_dir_left <= 1'b0;
    end else if (w_run && LP_XMAX != 16'd0) begin
      if (!r_dir_left) begin
        if (r_sprite_x == LP_XMAX) begin
          r_dir_left <= 1'b1;
          r_sprite_x <= r_sprite_x - 16'd1;
        end else begin
          r_sprite_x <= r_sprite_x + 16'd1;
        end
      end else begin
        if (r_sprite_x == 16'd0) begin
          r_dir_left <= 1'b0;
          r_sprite_x <= r_sprite_x + 16'd1;
        end else begin
          r_sprite_x <= r_sprite_x - 16'd1;
        end
      end
    end
  end

  assign sprite_x = r_sprite_x;
`else
  assign sprite_x = LP_XMID;
`endif

  assign base_r    = r_base_r;
  assign base_g    = r_base_g;
  assign base_b    = r_base_b;
  assign phase     = r_phase;
  assign frame_cnt = r_frame_cnt;
  assign sof_pulse = r_sof;
endmodule
